// File: rtl/timed_overlay_if.sv
`default_nettype none
// ============================================================================
// Module      : timed_overlay_if
// Description : Control, geometry and pixel-plot signals of the timed overlay.
// Revision    : 1.0 - initial release
// ============================================================================
interface timed_overlay_if #(
    parameter int X_W = 9,
    parameter int Y_W = 8,
    parameter int C_W = 3
);
    logic           start;
    logic           abort;
    logic           frame_tick;
    logic [X_W-1:0] ax;
    logic [X_W-1:0] bx;
    logic [Y_W-1:0] ay;
    logic [Y_W-1:0] by;
    logic [C_W-1:0] color_in;
    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_out;
    logic [C_W-1:0] color_out;
    logic           plot_out;
    logic           done;
    logic           busy;

    modport master (
        output start, abort, frame_tick, ax, bx, ay, by, color_in,
        input  x_out, y_out, color_out, plot_out, done, busy
    );

    modport slave (
        input  start, abort, frame_tick, ax, bx, ay, by, color_in,
        output x_out, y_out, color_out, plot_out, done, busy
    );
endinterface
`default_nettype wire

// File: rtl/timed_overlay.sv
`default_nettype none
// ============================================================================
// Module      : timed_overlay
// Description : Draws a filled rectangle, holds it for a number of frame
//               ticks, optionally erases it, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module timed_overlay #(
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int C_W         = 3,
    parameter int HOLD_FRAMES = 30,
    parameter int CNT_W       = 5,
    parameter bit ERASE_EN    = 1'b1,
    parameter int ERASE_COLOR = 0
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    timed_overlay_if.slave bus
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_draw  = 3'd1;
    localparam logic [2:0] c_st_hold  = 3'd2;
    localparam logic [2:0] c_st_erase = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    localparam logic [CNT_W-1:0] c_hold_last   = CNT_W'(HOLD_FRAMES);
    localparam logic [C_W-1:0]   c_erase_color = C_W'(ERASE_COLOR);
    localparam bit               c_has_hold    = (HOLD_FRAMES != 0);

    logic [2:0]       r_state,  w_state_nxt;
    logic [X_W-1:0]   r_sx,     w_sx_nxt;
    logic [Y_W-1:0]   r_sy,     w_sy_nxt;
    logic [X_W-1:0]   r_xmin,   w_xmin_nxt;
    logic [X_W-1:0]   r_xmax,   w_xmax_nxt;
    logic [Y_W-1:0]   r_ymin,   w_ymin_nxt;
    logic [Y_W-1:0]   r_ymax,   w_ymax_nxt;
    logic [C_W-1:0]   r_color,  w_color_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;

    logic [X_W-1:0]   r_x_out,     w_x_out_nxt;
    logic [Y_W-1:0]   r_y_out,     w_y_out_nxt;
    logic [C_W-1:0]   r_color_out, w_color_out_nxt;
    logic             r_plot,      w_plot_nxt;
    logic             r_done,      w_done_nxt;
    logic             r_busy,      w_busy_nxt;

    logic             w_last;
    logic             w_abort;
    logic             w_scanning;
    logic [X_W-1:0]   w_adv_x;
    logic [Y_W-1:0]   w_adv_y;
    logic [CNT_W-1:0] w_cnt_inc;

    // Last pixel is detected before incrementing, so all-ones corners never wrap
    assign w_last     = (r_sx == r_xmax) && (r_sy == r_ymax);
    assign w_adv_x    = (r_sx == r_xmax) ? r_xmin : (r_sx + X_W'(1));
    assign w_adv_y    = (r_sx == r_xmax) ? (r_sy + Y_W'(1)) : r_sy;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_abort    = bus.abort && (r_state != c_st_idle);
    assign w_scanning = (r_state == c_st_draw) || (r_state == c_st_erase);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_st_idle;
            r_sx        <= '0;
            r_sy        <= '0;
            r_xmin      <= '0;
            r_xmax      <= '0;
            r_ymin      <= '0;
            r_ymax      <= '0;
            r_color     <= '0;
            r_cnt       <= '0;
            r_x_out     <= '0;
            r_y_out     <= '0;
            r_color_out <= '0;
            r_plot      <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sx        <= w_sx_nxt;
            r_sy        <= w_sy_nxt;
            r_xmin      <= w_xmin_nxt;
            r_xmax      <= w_xmax_nxt;
            r_ymin      <= w_ymin_nxt;
            r_ymax      <= w_ymax_nxt;
            r_color     <= w_color_nxt;
            r_cnt       <= w_cnt_nxt;
            r_x_out     <= w_x_out_nxt;
            r_y_out     <= w_y_out_nxt;
            r_color_out <= w_color_out_nxt;
            r_plot      <= w_plot_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sx_nxt    = r_sx;
        w_sy_nxt    = r_sy;
        w_xmin_nxt  = r_xmin;
        w_xmax_nxt  = r_xmax;
        w_ymin_nxt  = r_ymin;
        w_ymax_nxt  = r_ymax;
        w_color_nxt = r_color;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            c_st_idle: begin
                if (bus.start) begin
                    w_xmin_nxt  = (bus.ax < bus.bx) ? bus.ax : bus.bx;
                    w_xmax_nxt  = (bus.ax < bus.bx) ? bus.bx : bus.ax;
                    w_ymin_nxt  = (bus.ay < bus.by) ? bus.ay : bus.by;
                    w_ymax_nxt  = (bus.ay < bus.by) ? bus.by : bus.ay;
                    w_color_nxt = bus.color_in;
                    w_sx_nxt    = w_xmin_nxt;
                    w_sy_nxt    = w_ymin_nxt;
                    w_state_nxt = c_st_draw;
                end
            end
            c_st_draw: begin
                if (!w_last) begin
                    w_sx_nxt = w_adv_x;
                    w_sy_nxt = w_adv_y;
                end else if (c_has_hold) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_st_hold;
                end else if (ERASE_EN) begin
                    w_sx_nxt    = r_xmin;
                    w_sy_nxt    = r_ymin;
                    w_state_nxt = c_st_erase;
                end else begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_hold: begin
                if (bus.frame_tick) begin
                    if (w_cnt_inc == c_hold_last) begin
                        if (ERASE_EN) begin
                            w_sx_nxt    = r_xmin;
                            w_sy_nxt    = r_ymin;
                            w_state_nxt = c_st_erase;
                        end else begin
                            w_state_nxt = c_st_done;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            c_st_erase: begin
                if (!w_last) begin
                    w_sx_nxt = w_adv_x;
                    w_sy_nxt = w_adv_y;
                end else begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase

        if (w_abort) begin
            w_state_nxt = c_st_idle;
        end
    end

    // Outputs are a registered view of the current state; abort silences them at once
    always_comb begin
        w_x_out_nxt     = r_x_out;
        w_y_out_nxt     = r_y_out;
        w_color_out_nxt = r_color_out;
        w_plot_nxt      = w_scanning && !w_abort;
        w_done_nxt      = (r_state == c_st_done) && !w_abort;
        w_busy_nxt      = (r_state != c_st_idle) && !w_abort;
        if (w_scanning) begin
            w_x_out_nxt     = r_sx;
            w_y_out_nxt     = r_sy;
            w_color_out_nxt = (r_state == c_st_erase) ? c_erase_color : r_color;
        end
    end

    assign bus.x_out     = r_x_out;
    assign bus.y_out     = r_y_out;
    assign bus.color_out = r_color_out;
    assign bus.plot_out  = r_plot;
    assign bus.done      = r_done;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_timed_overlay.sv
`default_nettype none
// ============================================================================
// Module      : tb_timed_overlay
// Description : Self-checking bench; DUT a holds 3 ticks and erases, DUT b
//               has no hold and no erase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timed_overlay;

    localparam int A_HOLD = 3;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    timed_overlay_if #(.X_W(9), .Y_W(8), .C_W(3)) ia ();
    timed_overlay_if #(.X_W(9), .Y_W(8), .C_W(3)) ib ();

    timed_overlay #(
        .X_W(9), .Y_W(8), .C_W(3), .HOLD_FRAMES(A_HOLD), .CNT_W(3),
        .ERASE_EN(1'b1), .ERASE_COLOR(0)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ia.slave)
    );

    timed_overlay #(
        .X_W(9), .Y_W(8), .C_W(3), .HOLD_FRAMES(0), .CNT_W(5),
        .ERASE_EN(1'b0), .ERASE_COLOR(0)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_noise(input bit on);
        ia.start = on ? 1'($urandom_range(0, 1)) : 1'b0;
        if (on) begin
            ia.ax       = 9'($urandom);
            ia.bx       = 9'($urandom);
            ia.ay       = 8'($urandom);
            ia.by       = 8'($urandom);
            ia.color_in = 3'($urandom);
        end
    endtask

    // One full overlay on DUT a, compared cycle by cycle with the expected trace
    task automatic run_a(input logic [8:0] ax_v, input logic [8:0] bx_v,
                         input logic [7:0] ay_v, input logic [7:0] by_v,
                         input logic [2:0] col, input bit noise, input bit do_abort,
                         input string tag);
        int px[$];
        int py[$];
        int xlo, xhi, ylo, yhi, ticks, guard;
        xlo = (ax_v < bx_v) ? int'(ax_v) : int'(bx_v);
        xhi = (ax_v < bx_v) ? int'(bx_v) : int'(ax_v);
        ylo = (ay_v < by_v) ? int'(ay_v) : int'(by_v);
        yhi = (ay_v < by_v) ? int'(by_v) : int'(ay_v);
        for (int y = ylo; y <= yhi; y++)
            for (int x = xlo; x <= xhi; x++) begin
                px.push_back(x);
                py.push_back(y);
            end

        @(negedge clk);
        ia.ax = ax_v; ia.bx = bx_v; ia.ay = ay_v; ia.by = by_v; ia.color_in = col;
        ia.start = 1'b1; ia.frame_tick = 1'b0; ia.abort = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (ia.plot_out !== 1'b0 || ia.busy !== 1'b0 || ia.done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start_edge: plot=%b busy=%b done=%b, want 0/0/0",
                     tag, ia.plot_out, ia.busy, ia.done);
        end

        for (int i = 0; i < px.size(); i++) begin
            @(negedge clk);
            drive_noise(noise);
            ia.frame_tick = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n_tests++;
            if (ia.plot_out !== 1'b1 || ia.x_out !== 9'(px[i]) || ia.y_out !== 8'(py[i]) ||
                ia.color_out !== col || ia.busy !== 1'b1 || ia.done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s draw[%0d]: got p=%b (%0d,%0d) c=%0d busy=%b done=%b, want p=1 (%0d,%0d) c=%0d busy=1 done=0",
                         tag, i, ia.plot_out, ia.x_out, ia.y_out, ia.color_out, ia.busy, ia.done,
                         px[i], py[i], col);
            end
        end

        ticks = 0;
        guard = 0;
        while (ticks < A_HOLD) begin
            @(negedge clk);
            drive_noise(noise);
            ia.frame_tick = ($urandom_range(0, 2) == 0);
            ia.abort      = do_abort && ia.frame_tick && (ticks == 1);
            @(posedge clk); #1;
            if (ia.abort) begin
                n_tests++;
                if (ia.busy !== 1'b0 || ia.plot_out !== 1'b0 || ia.done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s abort_edge: busy=%b plot=%b done=%b, want 0/0/0",
                             tag, ia.busy, ia.plot_out, ia.done);
                end
                ia.abort = 1'b0;
                repeat (A_HOLD + 3) begin
                    @(negedge clk);
                    ia.start = 1'b0;
                    ia.frame_tick = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    n_tests++;
                    if (ia.busy !== 1'b0 || ia.plot_out !== 1'b0 || ia.done !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s after_abort: busy=%b plot=%b done=%b, want 0/0/0",
                                 tag, ia.busy, ia.plot_out, ia.done);
                    end
                end
                return;
            end
            if (ia.frame_tick) ticks++;
            n_tests++;
            if (ia.plot_out !== 1'b0 || ia.done !== 1'b0 || ia.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s hold (ticks=%0d): plot=%b done=%b busy=%b, want 0/0/1",
                         tag, ticks, ia.plot_out, ia.done, ia.busy);
            end
            guard++;
            if (guard > 300) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s hold_timeout: ticks=%0d, want %0d", tag, ticks, A_HOLD);
                return;
            end
        end

        for (int i = 0; i < px.size(); i++) begin
            @(negedge clk);
            drive_noise(noise);
            ia.frame_tick = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n_tests++;
            if (ia.plot_out !== 1'b1 || ia.x_out !== 9'(px[i]) || ia.y_out !== 8'(py[i]) ||
                ia.color_out !== 3'd0 || ia.done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s erase[%0d]: got p=%b (%0d,%0d) c=%0d done=%b, want p=1 (%0d,%0d) c=0 done=0",
                         tag, i, ia.plot_out, ia.x_out, ia.y_out, ia.color_out, ia.done, px[i], py[i]);
            end
        end

        @(negedge clk);
        ia.start = 1'b0;
        ia.frame_tick = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (ia.done !== 1'b1 || ia.plot_out !== 1'b0 || ia.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_pulse: done=%b plot=%b busy=%b, want 1/0/1",
                     tag, ia.done, ia.plot_out, ia.busy);
        end
    endtask

    task automatic idle_check(input string tag, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            ia.start = 1'b0;
            ia.frame_tick = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n_tests++;
            if (ia.busy !== 1'b0 || ia.plot_out !== 1'b0 || ia.done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s idle: busy=%b plot=%b done=%b, want 0/0/0",
                         tag, ia.busy, ia.plot_out, ia.done);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ia.start = 1'b0; ia.abort = 1'b0; ia.frame_tick = 1'b0;
        ia.ax = '0; ia.bx = '0; ia.ay = '0; ia.by = '0; ia.color_in = '0;
        ib.start = 1'b0; ib.abort = 1'b0; ib.frame_tick = 1'b0;
        ib.ax = '0; ib.bx = '0; ib.ay = '0; ib.by = '0; ib.color_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({ia.x_out, ia.y_out, ia.color_out, ia.plot_out, ia.done, ia.busy} !== '0 ||
            {ib.x_out, ib.y_out, ib.color_out, ib.plot_out, ib.done, ib.busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: a=%h b=%h, want 0",
                     {ia.x_out, ia.y_out, ia.color_out, ia.plot_out, ia.done, ia.busy},
                     {ib.x_out, ib.y_out, ib.color_out, ib.plot_out, ib.done, ib.busy});
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle_check("post_reset", 3);
    endtask

    task automatic test_directed();
        run_a(9'd10, 9'd11, 8'd20, 8'd21, 3'd4, 1'b0, 1'b0, "directed");
        idle_check("directed", 2);
    endtask

    task automatic test_swapped();
        run_a(9'd11, 9'd10, 8'd21, 8'd20, 3'd4, 1'b0, 1'b0, "swapped");
        idle_check("swapped", 2);
    endtask

    task automatic test_1x1_corner();
        run_a(9'd511, 9'd511, 8'd255, 8'd255, 3'd7, 1'b0, 1'b0, "corner_1x1");
        idle_check("corner_1x1", 2);
    endtask

    task automatic test_random();
        int w, h, x0, y0;
        for (int t = 0; t < 6; t++) begin
            w  = $urandom_range(0, 3);
            h  = $urandom_range(0, 2);
            x0 = ($urandom_range(0, 3) == 0) ? 511 - w : $urandom_range(0, 500);
            y0 = ($urandom_range(0, 3) == 0) ? 255 - h : $urandom_range(0, 240);
            if ($urandom_range(0, 1) == 1)
                run_a(9'(x0 + w), 9'(x0), 8'(y0), 8'(y0 + h), 3'($urandom), 1'b0, 1'b0, "random");
            else
                run_a(9'(x0), 9'(x0 + w), 8'(y0 + h), 8'(y0), 3'($urandom), 1'b0, 1'b0, "random");
        end
        idle_check("random", 2);
    endtask

    // DUT b: 3x1 strip, done right after the last pixel, ticks have no effect
    task automatic test_no_hold();
        int x0, y0;
        logic [2:0] col;
        for (int t = 0; t < 3; t++) begin
            x0  = $urandom_range(0, 509);
            y0  = $urandom_range(0, 255);
            col = 3'($urandom);
            @(negedge clk);
            ib.ax = 9'(x0 + 2); ib.bx = 9'(x0); ib.ay = 8'(y0); ib.by = 8'(y0);
            ib.color_in = col; ib.start = 1'b1;
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                ib.start = 1'b0;
                ib.frame_tick = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                n_tests++;
                if (ib.plot_out !== 1'b1 || ib.x_out !== 9'(x0 + i) || ib.y_out !== 8'(y0) ||
                    ib.color_out !== col) begin
                    n_fail++;
                    $display("FAIL no_hold draw[%0d]: got p=%b (%0d,%0d) c=%0d, want p=1 (%0d,%0d) c=%0d",
                             i, ib.plot_out, ib.x_out, ib.y_out, ib.color_out, x0 + i, y0, col);
                end
            end
            @(negedge clk);
            ib.frame_tick = 1'b0;
            @(posedge clk); #1;
            n_tests++;
            if (ib.done !== 1'b1 || ib.plot_out !== 1'b0 || ib.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL no_hold done: done=%b plot=%b busy=%b, want 1/0/1",
                         ib.done, ib.plot_out, ib.busy);
            end
            @(posedge clk); #1;
            n_tests++;
            if (ib.done !== 1'b0 || ib.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL no_hold after_done: done=%b busy=%b, want 0/0", ib.done, ib.busy);
            end
        end
    endtask

    task automatic test_abort();
        run_a(9'd40, 9'd42, 8'd7, 8'd8, 3'd3, 1'b0, 1'b1, "abort");
        run_a(9'd300, 9'd301, 8'd100, 8'd100, 3'd6, 1'b0, 1'b0, "after_abort_start");
        idle_check("abort", 2);
    endtask

    task automatic test_start_ignored();
        run_a(9'd200, 9'd202, 8'd33, 8'd31, 3'd5, 1'b1, 1'b0, "start_ignored");
        idle_check("start_ignored", 2);
    endtask

    task automatic test_back_to_back();
        run_a(9'd1, 9'd0, 8'd0, 8'd1, 3'd2, 1'b0, 1'b0, "b2b_first");
        run_a(9'd77, 9'd79, 8'd9, 8'd9, 3'd1, 1'b0, 1'b0, "b2b_second");
        idle_check("b2b", 2);
    endtask

    task automatic test_reset_mid_draw();
        @(negedge clk);
        ia.ax = 9'd100; ia.bx = 9'd103; ia.ay = 8'd50; ia.by = 8'd52; ia.color_in = 3'd5;
        ia.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ia.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (ia.plot_out !== 1'b1 || ia.x_out !== 9'd101) begin
            n_fail++;
            $display("FAIL mid_draw_pre: plot=%b x=%0d, want 1 101", ia.plot_out, ia.x_out);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({ia.x_out, ia.y_out, ia.color_out, ia.plot_out, ia.done, ia.busy} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: outputs=%h, want 0",
                     {ia.x_out, ia.y_out, ia.color_out, ia.plot_out, ia.done, ia.busy});
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle_check("after_reset_release", 6);
        run_a(9'd5, 9'd6, 8'd5, 8'd5, 3'd6, 1'b0, 1'b0, "after_reset_start");
        idle_check("after_reset_start", 2);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_directed();
        test_swapped();
        test_1x1_corner();
        test_random();
        test_no_hold();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_draw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timed_overlay.md
# timed_overlay

Parametrised overlay engine for the screen-drawing datapath. On `start` it latches a rectangle and a colour and streams the filled rectangle to the pixel-plot bus. It then holds the overlay for a programmable number of frame ticks, optionally erases it, and reports completion. It generalises the fixed square-plus-30-tick overlay into one block with configurable widths, hold length and erase mode, plus abort and busy.

## Interface

Parameters:
- `X_W`, default 9: x-coordinate width.
- `Y_W`, default 8: y-coordinate width.
- `C_W`, default 3: colour width.
- `HOLD_FRAMES`, default 30: number of `frame_tick` pulses to hold; 0 means skip the hold.
- `CNT_W`, default 5: hold-counter width; must satisfy 2^CNT_W > HOLD_FRAMES.
- `ERASE_EN`, default 1: when 1, redraw the rectangle in `ERASE_COLOR` after the hold.
- `ERASE_COLOR`, default 0: erase colour.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `abort` in 1: cancel any operation in progress.
- `frame_tick` in 1: one-cycle frame strobe, synchronous to `clk`.
- `ax`, `bx` in X_W: rectangle corner x coordinates, any order.
- `ay`, `by` in Y_W: rectangle corner y coordinates, any order.
- `color_in` in C_W: draw colour.
- `x_out` out X_W: pixel x.
- `y_out` out Y_W: pixel y.
- `color_out` out C_W: pixel colour.
- `plot_out` out 1: pixel write strobe.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: high in every state except IDLE.

## Operation

- States: IDLE, DRAW, HOLD, ERASE, DONE. All outputs are registered.
- IDLE, `start`=1: latch xmin=min(ax,bx), xmax=max(ax,bx), ymin=min(ay,by), ymax=max(ay,by) and `color_in`. Set the scan position to (xmin,ymin) and go to DRAW.
- Inputs `ax`..`color_in` are ignored outside IDLE. `start` outside IDLE is ignored; it is not queued.
- DRAW: emit one pixel per cycle in row-major order. x runs xmin..xmax, then y increments and x returns to xmin.
  - Corners are inclusive: the pixel count is (xmax-xmin+1)*(ymax-ymin+1).
  - A degenerate 1x1 rectangle emits exactly one pixel.
- After pixel (xmax,ymax):
  - HOLD_FRAMES>0: go to HOLD with the hold counter cleared.
  - HOLD_FRAMES=0: go to ERASE if ERASE_EN=1, otherwise to DONE.
- HOLD: `plot_out`=0. The counter increments on each `frame_tick` seen while in HOLD.
  - A tick that brings the count to HOLD_FRAMES exits HOLD: to ERASE if ERASE_EN=1, otherwise to DONE.
  - Ticks during DRAW, ERASE, DONE or IDLE are not counted.
- ERASE: same scan as DRAW with `color_out`=ERASE_COLOR. After the last pixel, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `abort` in any non-IDLE state: next state is IDLE. `plot_out`=0 and `done`=0 from the next cycle; no erase is performed. `abort` in IDLE has no effect. `abort` has priority over `start` and over every state transition.
- Arithmetic: scan counters are X_W/Y_W wide. xmax and ymax are compared before incrementing, so no wrap occurs even at coordinate all-ones.

## Timing

- Reset values: state IDLE; `x_out`=0, `y_out`=0, `color_out`=0, `plot_out`=0, `done`=0, `busy`=0; hold counter 0.
- Reset asserted mid-operation clears everything immediately (asynchronously). No `done` is produced.
- `start` sampled at edge k:
  - `busy`=1 and `plot_out`=1 with the first pixel (xmin,ymin) valid after edge k+1.
  - The pixel stream is contiguous, with `plot_out` high for N consecutive cycles.
- DRAW→HOLD: `plot_out` falls on the edge after the last pixel.
- Hold exit: the tick sampled at edge t (the HOLD_FRAMES-th tick) gives the first erase pixel, or `done`, after edge t+1.
- `done` rises on the edge after the last erase pixel (or after the last draw pixel / hold exit when there is no erase). `busy` falls on the same edge as `done` falls.
- Back-to-back use: a `start` sampled the cycle after `done` is accepted.

## Test plan

- HOLD_FRAMES=3, ERASE_EN=1; start with (10,20)-(11,21), color 4 -> plots (10,20),(11,20),(10,21),(11,21) at colour 4 on consecutive cycles. After the 3rd tick, the same 4 plots at colour 0 follow, then one `done` pulse.
- Swapped corners (11,21)/(10,20) -> output identical to the previous scenario. Also 1x1 at (511,255) -> exactly 1 plot at (511,255), with no wrap.
- HOLD_FRAMES=0, ERASE_EN=0; 3x1 rectangle -> 3 plots, and `done` on the next cycle. Ticks sent during DRAW do not shorten a later HOLD.
- `abort` during the 2nd hold tick -> no erase plots, no `done`, `busy`=0 next cycle. A fresh `start` is then accepted.
- `start` pulsed with new coordinates during DRAW and HOLD -> ignored, and the original rectangle completes unchanged.
- `reset_n` low mid-DRAW -> all outputs 0 immediately (asynchronously). After release the block sits in IDLE until `start`.
